// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, fetch FSM encoding and queue entry type
package pipe_pkg;
   localparam int INSN_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [INSN_W-1:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc_plus4;
      logic [INSN_W-1:0] insn;
   } ifq_entry_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - instruction queue: DEPTH entries of {pc+4, insn}, flush wins
module ifq_fifo
   import pipe_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      push,
   input  ifq_entry_t                push_data,
   input  logic                      pop,
   output ifq_entry_t                head_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty
);
   localparam int AW = $clog2(DEPTH);

   ifq_entry_t     mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  last_ptr;
   logic           do_push;
   logic           do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign last_ptr = wr_ptr - 1'b1;

   // When empty the head shows the most recently written slot.
   assign head_data = empty ? mem[last_ptr] : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '{pc_plus4: '0, insn: NOP};
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ifetch_prefetch.sv
// rtl/ifetch_prefetch.sv - sequential instruction prefetcher with redirect flush
module ifetch_prefetch
   import pipe_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [INSN_W-1:0] mem_rdata,
   output logic              ins_valid,
   output logic [INSN_W-1:0] ins_out,
   output logic [ADDR_W-1:0] pc_plus4_out,
   input  logic              ins_rd,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc
);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t      state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] fetch_pc_inc;
   logic [ADDR_W-1:0] target_pc;
   logic [CW-1:0]     count;
   logic [CW:0]       count_after_push;
   logic              room_after_push;
   logic              full;
   logic              empty;
   logic              pop_eff;
   logic              push;
   ifq_entry_t        push_entry;
   ifq_entry_t        head;

   assign fetch_pc_inc     = fetch_pc + 32'd4;
   assign target_pc        = word_align(redirect_pc);
   assign pop_eff          = ins_rd && !empty;
   assign push             = (state == ST_REQ) && mem_ack && !redirect;
   assign push_entry       = '{pc_plus4: fetch_pc_inc, insn: mem_rdata};
   assign count_after_push = {1'b0, count} - {{CW{1'b0}}, pop_eff} + {{CW{1'b0}}, 1'b1};
   assign room_after_push  = (count_after_push < (CW+1)'(DEPTH));

   assign ins_valid    = !empty;
   assign ins_out      = head.insn;
   assign pc_plus4_out = head.pc_plus4;

   ifq_fifo #(.DEPTH(DEPTH)) u_ifq (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (push),
      .push_data (push_entry),
      .pop       (ins_rd),
      .head_data (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (redirect) begin
                  fetch_pc <= target_pc;
               end else if (!full || pop_eff) begin
                  state    <= ST_REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= fetch_pc;
               end
            end
            ST_REQ: begin
               if (redirect) begin
                  fetch_pc <= target_pc;
                  if (mem_ack) begin
                     mem_addr <= target_pc;
                  end else begin
                     // The outstanding request must complete before retargeting.
                     state <= ST_DROP;
                  end
               end else if (mem_ack) begin
                  fetch_pc <= fetch_pc_inc;
                  if (room_after_push) begin
                     mem_addr <= fetch_pc_inc;
                  end else begin
                     state   <= ST_IDLE;
                     mem_req <= 1'b0;
                  end
               end
            end
            ST_DROP: begin
               if (redirect) begin
                  fetch_pc <= target_pc;
               end
               if (mem_ack) begin
                  state    <= ST_REQ;
                  mem_addr <= redirect ? target_pc : fetch_pc;
               end
            end
            default: begin
               state   <= ST_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end
endmodule
